// File: rtl/conv_arbiter_if.sv
// Conv datatypes plus the requester/ConvUnit bundle used by conv_arbiter.
// Latency: none (wires only).
// Backpressure: carries valid/ready pairs for requests, responses and the ConvUnit link.
// Ports (slave = arbiter view):
//   req_valid/req_ready/req_data/req_kernel   per-requester job handshake
//   rsp_valid/rsp_ready/rsp_result            per-requester result handshake, shared result bus
//   conv_in_*/conv_kernel/conv_result/conv_out_*  link to the shared ConvUnit
package Conv;
    localparam int LEN    = 4;
    localparam int DATA_W = 64;
    typedef logic [DATA_W-1:0] data_t;
    typedef data_t [LEN-1:0]   data_vector;
    typedef logic [63:0]       result_t;
endpackage

interface conv_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    Conv::data_t [NUM_REQ-1:0]       req_data;
    Conv::data_vector [NUM_REQ-1:0]  req_kernel;

    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0]              rsp_ready;
    Conv::result_t                   rsp_result;

    Conv::data_t                     conv_in_data;
    Conv::data_vector                conv_kernel;
    logic                            conv_in_valid;
    logic                            conv_in_ready;
    Conv::result_t                   conv_result;
    logic                            conv_out_valid;
    logic                            conv_out_ready;

    modport slave (
        input  req_valid, req_data, req_kernel, rsp_ready,
        input  conv_in_ready, conv_result, conv_out_valid,
        output req_ready, rsp_valid, rsp_result,
        output conv_in_data, conv_kernel, conv_in_valid, conv_out_ready
    );

    modport master (
        output req_valid, req_data, req_kernel, rsp_ready,
        output conv_in_ready, conv_result, conv_out_valid,
        input  req_ready, rsp_valid, rsp_result,
        input  conv_in_data, conv_kernel, conv_in_valid, conv_out_ready
    );
endinterface

// File: rtl/conv_arbiter.sv
// Round-robin share of one in-order ConvUnit between NUM_REQ requesters; result routing via a tag FIFO.
// Latency: request handshake -> conv_in_valid 1 cycle; results routed combinationally to the owner.
// Backpressure: no grant while MAX_OUT jobs are in flight; a stalled head owner stalls all later results.
// Ports: clk, rst (async active-low), bus (conv_arbiter_if.slave), outstanding (tag FIFO occupancy),
//        orphan_err (sticky: a result arrived with nothing in flight).
module conv_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int MAX_OUT = 4,   // power of two, >= 2, so tag pointers wrap naturally
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    conv_arbiter_if.slave     bus,
    output logic [CNT_W-1:0]  outstanding,
    output logic              orphan_err
);
    localparam int AW = $clog2(MAX_OUT);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  pend_q;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  head;
    logic             can_grant;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    logic [ID_W-1:0]  tag_mem [MAX_OUT];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Scan downward so the last hit is the nearest valid requester after ptr_q.
    always_comb begin
        grant = ptr_q;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                grant = cand;
            end
        end
    end

    assign can_grant     = rst && (state_q == IDLE) && (|bus.req_valid)
                           && (count_q < CNT_W'(MAX_OUT));
    assign bus.req_ready = can_grant ? (NUM_REQ'(1) << grant) : '0;
    assign push          = (state_q == ISSUE) && bus.conv_in_ready;
    assign bus.conv_in_valid = (state_q == ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_grant)         state_d = ISSUE;
            ISSUE:   if (bus.conv_in_ready) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Job capture: operands are held stable for the whole ISSUE phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q            <= ID_W'(NUM_REQ - 1);
            pend_q           <= '0;
            bus.conv_in_data <= '0;
            bus.conv_kernel  <= '0;
        end else if (can_grant) begin
            ptr_q            <= grant;
            pend_q           <= grant;
            bus.conv_in_data <= bus.req_data[grant];
            bus.conv_kernel  <= bus.req_kernel[grant];
        end
    end

    // Response routing: the oldest in-flight tag owns whatever ConvUnit presents.
    assign fifo_empty         = (count_q == '0);
    assign head               = tag_mem[rd_ptr];
    assign bus.rsp_result     = bus.conv_result;
    assign bus.rsp_valid      = (rst && !fifo_empty && bus.conv_out_valid)
                                ? (NUM_REQ'(1) << head) : '0;
    // With nothing in flight, accept (and drop) anything ConvUnit offers.
    assign bus.conv_out_ready = rst && (fifo_empty || bus.rsp_ready[head]);
    assign pop                = !fifo_empty && bus.conv_out_valid && bus.conv_out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (fifo_empty && bus.conv_out_valid) begin
                orphan_err <= 1'b1;
            end
        end
    end

    assign outstanding = count_q;
endmodule

// File: tb/tb_conv_arbiter.sv
module tb_conv_arbiter;
    localparam int N = 4;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_arbiter_if #(.NUM_REQ(N)) bus();
    logic [2:0] outstanding;
    logic       orphan_err;

    conv_arbiter #(.NUM_REQ(N), .MAX_OUT(M)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int               m_ptr  = N - 1;
    bit               m_busy = 0;
    int               m_pend = 0;
    Conv::data_t      m_data = '0;
    Conv::data_vector m_kern = '0;
    int               q[$];
    bit               m_orph = 0;

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] r;
        r = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int id;
        if (!rst || m_busy || q.size() >= M) return '0;
        id = rr_pick(m_ptr, bus.req_valid);
        if (id < 0) return '0;
        return oh(id);
    endfunction

    always @(negedge rst) begin
        q.delete();
        m_busy = 0;
        m_ptr  = N - 1;
        m_orph = 0;
    end

    always @(posedge clk) begin
        int id;
        logic [N-1:0] rdy;
        cyc++;
        if (rst) begin
            rdy = exp_ready();
            if (q.size() > 0) begin
                if (bus.conv_out_valid && bus.rsp_ready[q[0]]) void'(q.pop_front());
            end else if (bus.conv_out_valid) begin
                m_orph = 1;
            end
            if (m_busy) begin
                if (bus.conv_in_ready) begin
                    q.push_back(m_pend);
                    m_busy = 0;
                end
            end else if (rdy != '0) begin
                id     = rr_pick(m_ptr, bus.req_valid);
                m_pend = id;
                m_ptr  = id;
                m_data = bus.req_data[id];
                m_kern = bus.req_kernel[id];
                m_busy = 1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] ev;
        if (chk_en) begin
            chk("req_ready", bus.req_ready, exp_ready());
            chk("conv_in_valid", bus.conv_in_valid, m_busy);
            if (m_busy) begin
                chk("conv_in_data", bus.conv_in_data, m_data);
                chk("conv_kernel", bus.conv_kernel, m_kern);
            end
            chk("outstanding", outstanding, q.size());
            if (rst && q.size() > 0) begin
                ev = bus.conv_out_valid ? oh(q[0]) : '0;
                chk("rsp_valid", bus.rsp_valid, ev);
                chk("conv_out_ready", bus.conv_out_ready, bus.rsp_ready[q[0]]);
                if (ev != '0) chk("rsp_result", bus.rsp_result, bus.conv_result);
            end else begin
                chk("rsp_valid_idle", bus.rsp_valid, '0);
                if (bus.conv_out_valid) chk("conv_out_ready_idle", bus.conv_out_ready, rst);
            end
            chk("orphan_err", orphan_err, m_orph);
        end
    end

    // Grant log for sequence/spacing checks.
    int glog[$];
    int gcyc[$];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid      = '0;
        bus.conv_in_ready  = 1'b0;
        bus.conv_out_valid = 1'b0;
        bus.rsp_ready      = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_conv_in_valid", bus.conv_in_valid, 1'b0);
        chk("rst_conv_in_data", bus.conv_in_data, 64'd0);
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_conv_out_ready", bus.conv_out_ready, 1'b0);
        chk("rst_orphan_err", orphan_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        glog.delete();
        gcyc.delete();
    endtask

    task automatic wait_grants(input int n);
        int cnt = 0;
        while (glog.size() < n && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("wait_grants", glog.size(), n);
    endtask

    // ConvUnit model that returns a result whenever something is in flight.
    task automatic drain();
        int cnt = 0;
        bus.conv_in_ready = 1'b1;
        bus.rsp_ready     = '1;
        while ((outstanding != 0 || bus.conv_in_valid) && cnt < 60) begin
            tick();
            bus.conv_out_valid = (outstanding != 0);
            bus.conv_result    = 64'hD000_0000_0000_0000 | 64'(cnt);
            cnt++;
        end
        bus.conv_out_valid = 1'b0;
        chk("drain_done", outstanding, 3'd0);
    endtask

    initial begin
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        int cnt;
        bus.req_valid      = '0;
        bus.rsp_ready      = '0;
        bus.conv_in_ready  = 1'b0;
        bus.conv_out_valid = 1'b0;
        bus.conv_result    = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
            for (int j = 0; j < Conv::LEN; j++)
                bus.req_kernel[i][j] = {48'hC0DE_0000_0000, 8'(i), 8'(j)};
        end

        do_reset();
        chk_en = 1;

        // Single job from requester 2
        bus.req_valid     = 4'b0100;
        bus.req_data[2]   = 64'h0123_4567_89AB_CDEF;
        bus.conv_in_ready = 1'b1;
        bus.rsp_ready     = 4'b1111;
        @(negedge clk);
        chk("t1_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_conv_in_valid", bus.conv_in_valid, 1'b1);
        chk("t1_conv_in_data", bus.conv_in_data, 64'h0123_4567_89AB_CDEF);
        tick();
        @(negedge clk);
        chk("t1_outstanding1", outstanding, 3'd1);
        tick();
        bus.conv_out_valid = 1'b1;
        bus.conv_result    = 64'hFACE_0000_1234_5678;
        @(negedge clk);
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("t1_rsp_result", bus.rsp_result, 64'hFACE_0000_1234_5678);
        tick();
        bus.conv_out_valid = 1'b0;
        @(negedge clk);
        chk("t1_outstanding0", outstanding, 3'd0);

        // Fairness: all requesters valid, results drained as they appear
        do_reset();
        bus.conv_in_ready = 1'b1;
        bus.rsp_ready     = '1;
        bus.req_valid     = 4'b1111;
        cnt = 0;
        while (glog.size() < 6 && cnt < 60) begin
            tick();
            bus.conv_out_valid = (outstanding != 0);
            cnt++;
        end
        bus.req_valid = '0;
        drain();
        chk("t2_issues", glog.size(), 6);
        if (glog.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("t2_grant%0d", k), glog[k], exp_seq[k]);
            for (int k = 1; k < 6; k++) chk($sformatf("t2_gap%0d", k), gcyc[k] - gcyc[k-1], 2);
        end

        // Full FIFO: ConvUnit never returns results
        do_reset();
        bus.conv_in_ready = 1'b1;
        bus.req_valid     = 4'b1111;
        repeat (12) tick();
        chk("t3_issues", glog.size(), 4);
        chk("t3_outstanding_full", outstanding, 3'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_req_ready_blocked", bus.req_ready, 4'b0000);
        end
        tick();
        bus.rsp_ready      = '1;
        bus.conv_out_valid = 1'b1;
        bus.conv_result    = 64'h0000_0000_0000_0333;
        tick();
        bus.conv_out_valid = 1'b0;
        @(negedge clk);
        chk("t3_outstanding_after_pop", outstanding, 3'd3);
        repeat (4) tick();
        chk("t3_one_more_issue", glog.size(), 5);
        chk("t3_outstanding_refull", outstanding, 3'd4);
        if (glog.size() == 5) chk("t3_fifth_grant", glog[4], 0);
        bus.req_valid = '0;
        drain();

        // Response backpressure: jobs from 1 then 3, owner 1 stalls
        do_reset();
        bus.conv_in_ready = 1'b1;
        bus.req_valid     = 4'b1010;
        wait_grants(2);
        bus.req_valid = '0;
        tick();
        chk("t4_outstanding", outstanding, 3'd2);
        if (glog.size() == 2) begin
            chk("t4_first", glog[0], 1);
            chk("t4_second", glog[1], 3);
        end
        bus.rsp_ready      = 4'b1101;
        bus.conv_out_valid = 1'b1;
        bus.conv_result    = 64'h0000_0000_0000_0111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_rsp_valid", bus.rsp_valid, 4'b0010);
            chk("t4_stall_out_ready", bus.conv_out_ready, 1'b0);
        end
        tick();
        bus.rsp_ready = 4'b1111;
        @(negedge clk);
        chk("t4_serve1_valid", bus.rsp_valid, 4'b0010);
        chk("t4_serve1_ready", bus.conv_out_ready, 1'b1);
        chk("t4_serve1_result", bus.rsp_result, 64'h0000_0000_0000_0111);
        tick();
        bus.conv_result = 64'h0000_0000_0000_0333;
        @(negedge clk);
        chk("t4_serve3_valid", bus.rsp_valid, 4'b1000);
        chk("t4_serve3_result", bus.rsp_result, 64'h0000_0000_0000_0333);
        tick();
        bus.conv_out_valid = 1'b0;
        @(negedge clk);
        chk("t4_outstanding0", outstanding, 3'd0);

        // Reset in the middle of an ISSUE with two jobs in flight
        do_reset();
        bus.conv_in_ready = 1'b1;
        bus.req_valid     = 4'b0011;
        wait_grants(2);
        bus.req_valid = '0;
        tick();
        bus.conv_in_ready = 1'b0;
        bus.req_valid     = 4'b0100;
        cnt = 0;
        while (!bus.conv_in_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        bus.req_valid = 4'b1111;
        chk("t5_stalled_issue", {bus.conv_in_valid, outstanding}, {1'b1, 3'd2});
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_conv_in_valid", bus.conv_in_valid, 1'b0);
        chk("t5_async_outstanding", outstanding, 3'd0);
        chk("t5_async_req_ready", bus.req_ready, 4'b0000);
        tick();
        glog.delete();
        gcyc.delete();
        rst = 1'b1;
        bus.conv_in_ready = 1'b1;
        @(negedge clk);
        chk("t5_first_ready", bus.req_ready, 4'b0001);
        wait_grants(1);
        if (glog.size() >= 1) chk("t5_first_grant", glog[0], 0);
        bus.req_valid = '0;
        drain();

        // Orphan result with nothing in flight
        tick();
        bus.conv_out_valid = 1'b1;
        bus.conv_result    = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("t6_out_ready", bus.conv_out_ready, 1'b1);
        chk("t6_rsp_valid", bus.rsp_valid, 4'b0000);
        tick();
        bus.conv_out_valid = 1'b0;
        @(negedge clk);
        chk("t6_orphan_set", orphan_err, 1'b1);
        glog.delete();
        bus.req_valid = 4'b1000;
        wait_grants(1);
        bus.req_valid = '0;
        drain();
        chk("t6_orphan_sticky", orphan_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("t6_orphan_cleared", orphan_err, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
